reg_file_bypass: RTL and testbench

Parametrised successor to the CPU register file: `READ_PORTS` combinational read ports, one synchronous write port with same-cycle write-to-read forwarding, a hardwired-zero register 0, a dedicated HI/LO register pair for multiply/divide results, and a per-register load scoreboard that flags operands whose pending load has not yet written back. It sits between decode and execute in the MIPS datapath and replaces the fixed two-read-port file. It keeps the debug tap of one architectural register for testbenches.

---
 rtl/reg_file_bypass.sv | 122 ++++++++++++
 tb/tb_reg_file_bypass.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/reg_file_bypass.sv
// reg_file_bypass
//   Register file sitting between decode and execute. It provides:
//   - READ_PORTS combinational read ports with same-cycle write forwarding
//   - one synchronous write port
//   - register 0 hardwired to zero
//   - a HI/LO pair for multiply/divide results
//   - a per-register load scoreboard (busy bits)
//
// Ports
//   clk        : clock, rising edge
//   reset      : asynchronous, active-low clear of all state
//   raddr      : packed read addresses, port i at [i*ADDR_WIDTH +: ADDR_WIDTH]
//   rdata      : packed read data, port i at [i*DATA_WIDTH +: DATA_WIDTH]
//   rbusy      : per-port "operand still waiting on a load"
//   waddr/wdata/wen     : write port
//   load_issue/load_rd  : marks load_rd busy until it is written
//   hilo_wen/hi_wdata/lo_wdata : HI/LO update
//   hi, lo     : registered HI/LO contents (no forwarding)
//   debug_reg  : register DEBUG_REG with forwarding applied

// One read port: forwarding mux plus the busy check.
module reg_file_bypass_rdport #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
) (
    input  logic [ADDR_WIDTH-1:0]                          raddr,
    input  logic [(1<<ADDR_WIDTH)-1:0][DATA_WIDTH-1:0]     regs,
    input  logic [(1<<ADDR_WIDTH)-1:0]                     busy,
    input  logic                                           wen,
    input  logic [ADDR_WIDTH-1:0]                          waddr,
    input  logic [DATA_WIDTH-1:0]                          wdata,
    output logic [DATA_WIDTH-1:0]                          rdata,
    output logic                                           rbusy
);
    logic hit;

    assign hit = wen && (waddr == raddr);

    // r0 is never forwarded, so it always reads its stored zero.
    assign rdata = (hit && (raddr != '0)) ? wdata : regs[raddr];

    // A write landing this cycle satisfies a pending load.
    assign rbusy = busy[raddr] & ~hit;
endmodule

module reg_file_bypass #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int READ_PORTS = 2,
    parameter int DEBUG_REG  = 2
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [READ_PORTS*ADDR_WIDTH-1:0] raddr,
    output logic [READ_PORTS*DATA_WIDTH-1:0] rdata,
    output logic [READ_PORTS-1:0]            rbusy,
    input  logic [ADDR_WIDTH-1:0]            waddr,
    input  logic [DATA_WIDTH-1:0]            wdata,
    input  logic                             wen,
    input  logic                             load_issue,
    input  logic [ADDR_WIDTH-1:0]            load_rd,
    input  logic                             hilo_wen,
    input  logic [DATA_WIDTH-1:0]            hi_wdata,
    input  logic [DATA_WIDTH-1:0]            lo_wdata,
    output logic [DATA_WIDTH-1:0]            hi,
    output logic [DATA_WIDTH-1:0]            lo,
    output logic [DATA_WIDTH-1:0]            debug_reg
);
    localparam int NREGS = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] DBG_IDX = ADDR_WIDTH'(DEBUG_REG);

    logic [NREGS-1:0][DATA_WIDTH-1:0] regs_q;
    logic [NREGS-1:0]                 busy_q;
    logic [DATA_WIDTH-1:0]            hi_q;
    logic [DATA_WIDTH-1:0]            lo_q;

    // Entry 0 is cleared by reset and never assigned afterwards, so it
    // stays zero and its busy bit can never set.
    // The load_issue update comes after the write so that, on the same
    // index, the younger load leaves the register busy.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            regs_q <= '0;
            busy_q <= '0;
            hi_q   <= '0;
            lo_q   <= '0;
        end else begin
            if (wen && (waddr != '0)) begin
                regs_q[waddr] <= wdata;
                busy_q[waddr] <= 1'b0;
            end
            if (load_issue && (load_rd != '0))
                busy_q[load_rd] <= 1'b1;
            if (hilo_wen) begin
                hi_q <= hi_wdata;
                lo_q <= lo_wdata;
            end
        end
    end

    for (genvar p = 0; p < READ_PORTS; p++) begin : g_rd
        reg_file_bypass_rdport #(
            .DATA_WIDTH(DATA_WIDTH),
            .ADDR_WIDTH(ADDR_WIDTH)
        ) u_rd (
            .raddr (raddr[p*ADDR_WIDTH +: ADDR_WIDTH]),
            .regs  (regs_q),
            .busy  (busy_q),
            .wen   (wen),
            .waddr (waddr),
            .wdata (wdata),
            .rdata (rdata[p*DATA_WIDTH +: DATA_WIDTH]),
            .rbusy (rbusy[p])
        );
    end

    assign hi = hi_q;
    assign lo = lo_q;

    assign debug_reg = (wen && (waddr == DBG_IDX) && (DBG_IDX != '0))
                       ? wdata : regs_q[DBG_IDX];
endmodule

// File: tb/tb_reg_file_bypass.sv
module tb_reg_file_bypass;
    localparam int DW = 32;
    localparam int AW = 5;
    localparam int RP = 3;

    logic            clk = 1'b0;
    logic            reset;
    logic [RP*AW-1:0] raddr;
    logic [RP*DW-1:0] rdata;
    logic [RP-1:0]    rbusy;
    logic [AW-1:0]    waddr;
    logic [DW-1:0]    wdata;
    logic             wen;
    logic             load_issue;
    logic [AW-1:0]    load_rd;
    logic             hilo_wen;
    logic [DW-1:0]    hi_wdata, lo_wdata;
    logic [DW-1:0]    hi, lo, debug_reg;

    int tests = 0;
    int fails = 0;

    reg_file_bypass #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .READ_PORTS(RP), .DEBUG_REG(2)) dut (
        .clk(clk), .reset(reset), .raddr(raddr), .rdata(rdata), .rbusy(rbusy),
        .waddr(waddr), .wdata(wdata), .wen(wen), .load_issue(load_issue),
        .load_rd(load_rd), .hilo_wen(hilo_wen), .hi_wdata(hi_wdata),
        .lo_wdata(lo_wdata), .hi(hi), .lo(lo), .debug_reg(debug_reg)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        wen = 1'b0; load_issue = 1'b0; hilo_wen = 1'b0;
    endtask

    function automatic logic [DW-1:0] rd(input int p);
        return rdata[p*DW +: DW];
    endfunction

    function automatic logic [RP*AW-1:0] ra(input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                                            input logic [AW-1:0] a2);
        return {a2, a1, a0};
    endfunction

    initial begin
        reset = 1'b0; raddr = '0; waddr = '0; wdata = '0; wen = 1'b0;
        load_issue = 1'b0; load_rd = '0; hilo_wen = 1'b0; hi_wdata = '0; lo_wdata = '0;
        #2;
        // Reset state before any clock
        chk("rst_rdata0", rd(0), 0);
        chk("rst_rbusy", DW'(rbusy), 0);
        chk("rst_hi", hi, 0);
        chk("rst_debug", debug_reg, 0);
        reset = 1'b1;

        // Load state, then pulse reset mid-cycle
        wen = 1; waddr = 5; wdata = 32'hDEADBEEF;
        hilo_wen = 1; hi_wdata = 32'h11; lo_wdata = 32'h22;
        load_issue = 1; load_rd = 6;
        tick(); idle();
        raddr = ra(5, 6, 0); #1;
        chk("pre_rst_r5", rd(0), 32'hDEADBEEF);
        chk("pre_rst_busy6", DW'(rbusy), 32'h2);
        chk("pre_rst_hi", hi, 32'h11);
        reset = 1'b0; #1;
        chk("async_rst_r5", rd(0), 0);
        chk("async_rst_rbusy", DW'(rbusy), 0);
        chk("async_rst_hi", hi, 0);
        chk("async_rst_lo", lo, 0);
        reset = 1'b1;
        tick();
        chk("post_rst_r5", rd(0), 0);

        // Write then read
        wen = 1; waddr = 1; wdata = 1; tick();
        waddr = 2; wdata = 2; tick(); idle();
        raddr = ra(1, 2, 0); #1;
        chk("rd_r1", rd(0), 1);
        chk("rd_r2", rd(1), 2);
        chk("debug_r2", debug_reg, 2);
        wen = 1; waddr = 2; wdata = 7; tick(); idle(); #1;
        chk("debug_r2_7", debug_reg, 7);
        wen = 1; waddr = 2; wdata = 9; #1;
        chk("debug_bypass", debug_reg, 9);
        idle(); #1;

        // Bypass
        wen = 1; waddr = 3; wdata = 32'h1234; raddr = ra(3, 0, 0); #1;
        chk("bypass_r3", rd(0), 32'h1234);
        tick();
        waddr = 0; wdata = 32'hFFFF; #1;
        chk("bypass_r0", rd(1), 0);
        tick(); idle(); #1;
        chk("r0_after_write", rd(1), 0);
        chk("r3_stored", rd(0), 32'h1234);

        // Scoreboard
        load_issue = 1; load_rd = 8; raddr = ra(8, 0, 0); #1;
        chk("busy_not_yet", DW'(rbusy), 0);
        tick(); idle(); #1;
        chk("busy_r8", DW'(rbusy), 1);
        wen = 1; waddr = 8; wdata = 32'h55; #1;
        chk("busy_clear_comb", DW'(rbusy), 0);
        chk("busy_bypass_data", rd(0), 32'h55);
        tick(); idle(); #1;
        chk("busy_stays_clear", DW'(rbusy), 0);
        chk("r8_stored", rd(0), 32'h55);
        load_issue = 1; load_rd = 0; tick(); idle(); raddr = ra(0, 0, 0); #1;
        chk("r0_never_busy", DW'(rbusy), 0);

        // Simultaneous issue and write to the same register
        load_issue = 1; load_rd = 9; wen = 1; waddr = 9; wdata = 32'hAA;
        tick(); idle(); raddr = ra(9, 0, 0); #1;
        chk("same_idx_data", rd(0), 32'hAA);
        chk("same_idx_busy", DW'(rbusy), 1);
        tick(); #1;
        chk("same_idx_busy_held", DW'(rbusy), 1);
        wen = 1; waddr = 9; wdata = 32'hBB; tick(); idle(); #1;
        chk("same_idx_cleared", DW'(rbusy), 0);
        chk("same_idx_new_data", rd(0), 32'hBB);

        // Issue and write to different registers; re-issue then one write
        load_issue = 1; load_rd = 10; wen = 1; waddr = 11; wdata = 32'h77;
        tick(); idle(); raddr = ra(10, 11, 0); #1;
        chk("diff_idx_busy", DW'(rbusy), 1);
        chk("diff_idx_data", rd(1), 32'h77);
        load_issue = 1; load_rd = 10; tick(); idle(); #1;
        chk("reissue_busy", DW'(rbusy), 1);
        wen = 1; waddr = 10; wdata = 32'h5; tick(); idle(); #1;
        chk("reissue_one_write", DW'(rbusy), 0);

        // HI/LO together with a regular write
        hilo_wen = 1; hi_wdata = 1; lo_wdata = 2; wen = 1; waddr = 4; wdata = 3; #1;
        chk("hi_not_yet", hi, 0);
        tick(); idle(); raddr = ra(4, 4, 4); #1;
        chk("hi", hi, 1);
        chk("lo", lo, 2);
        chk("r4_p0", rd(0), 3);
        chk("r4_p1", rd(1), 3);
        chk("r4_p2", rd(2), 3);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
